// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared types for the sram-like memory responder.
// Size codes, queue entry layout and LFSR constants.
package sram_like_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic [5:0]  timer;
    } entry_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Galois right-shift step, maximal length for these taps
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/sram_like_resp_if.sv
// sram_like_resp_if: request/response channel of the sram-like bus.
// master drives requests, slave answers with addr_ok/data_ok/rdata.
interface sram_like_resp_if;
    import sram_like_pkg::*;

    logic        req;
    logic        wr;
    size_e       size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_like_resp_fifo.sv
// sram_like_resp_fifo: in-order queue of accepted requests.
// Each entry carries a saturating countdown timer; head is exposed.
module sram_like_resp_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 push_e,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t        ent_q [DEPTH];
    entry_t        ent_d [DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (push) wp_d = wp_q + PW'(1);
        if (pop)  rp_d = rp_q + PW'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // All timers tick every cycle; stale slots are harmless
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].timer != '0) begin
                ent_d[i].timer = ent_q[i].timer - 6'd1;
            end
        end
        if (push) ent_d[wp_q] = push_e;
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = ent_q[rp_q];
    assign count = cnt_q;
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/sram_like_resp.sv
// sram_like_resp: sram-like responder over a word RAM, in-order fixed latency.
// Define SRAM_LIKE_RAND_DELAY_EN for LFSR-driven extra latency and stalls.
module sram_like_resp
    import sram_like_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 2,
    parameter int MAX_OUT   = 4
) (
    input  logic            clk,
    input  logic            reset,
    sram_like_resp_if.slave bus
);

    localparam int         AW    = $clog2(MEM_WORDS);
    localparam int         CW    = $clog2(MAX_OUT) + 1;
    localparam logic [5:0] TLOAD = 6'(LATENCY - 1);

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] idx;
    logic          accept;
    logic          stall;
    logic          full;
    logic          empty;
    logic          pop;
    logic [CW-1:0] count;
    logic [5:0]    extra;
    entry_t        head;
    entry_t        push_e;

    assign idx = bus.addr[AW+1:2];

`ifdef SRAM_LIKE_RAND_DELAY_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        unused_lfsr;

    assign lfsr_d = lfsr_step(lfsr_q);

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign extra       = {4'b0000, lfsr_q[1:0]};
    assign stall       = (lfsr_q[4:2] == 3'b000);
    assign unused_lfsr = ^lfsr_q[15:5];
`else
    assign extra = '0;
    assign stall = 1'b0;
`endif

    assign bus.addr_ok = !reset && !full && !stall;
    assign accept      = bus.req && bus.addr_ok;

    assign pop         = !reset && !empty && (head.timer == '0);
    assign bus.data_ok = pop;
    assign bus.rdata   = (pop && !head.wr) ? head.rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (accept && bus.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) begin
                    mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // Read captures the word before any same-edge write lands
    always_comb begin
        push_e       = '0;
        push_e.wr    = bus.wr;
        push_e.rdata = bus.wr ? 32'h0 : mem[idx];
        push_e.timer = TLOAD + extra;
    end

    sram_like_resp_fifo #(
        .DEPTH (MAX_OUT)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (accept),
        .pop    (pop),
        .push_e (push_e),
        .head   (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    logic unused_ok;
    assign unused_ok = ^{bus.size, bus.addr[31:AW+2], bus.addr[1:0], count};

endmodule

// File: tb/tb_sram_like_resp.sv
// tb_sram_like_resp: scoreboard bench for sram_like_resp at latencies 2, 8, 1.
// Driver queues expected responses on accept; monitor checks data and arrival cycle.
module tb_sram_like_resp;
    import sram_like_pkg::*;

    localparam int NI = 3;
    localparam int MW = 4096;

    typedef struct {
        logic [31:0] rd;
        int          due;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic        req_d  [NI];
    logic        wr_d   [NI];
    logic [31:0] addr_d [NI];
    logic [3:0]  ws_d   [NI];
    logic [31:0] wd_d   [NI];
    logic        aok    [NI];
    logic        dok    [NI];
    logic [31:0] rdo    [NI];
    exp_t        q      [NI][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 8 : 1;
    endfunction

    sram_like_resp_if bus [NI] ();

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : (g == 1) ? 8 : 1;
        sram_like_resp #(
            .MEM_WORDS (MW),
            .LATENCY   (L),
            .MAX_OUT   (4)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus[g])
        );
        assign bus[g].req   = req_d[g];
        assign bus[g].wr    = wr_d[g];
        assign bus[g].size  = SZ_WORD;
        assign bus[g].addr  = addr_d[g];
        assign bus[g].wstrb = ws_d[g];
        assign bus[g].wdata = wd_d[g];
        assign aok[g]       = bus[g].addr_ok;
        assign dok[g]       = bus[g].data_ok;
        assign rdo[g]       = bus[g].rdata;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (dok[i]) begin
                if (q[i].size() == 0) begin
                    chk($sformatf("unexp_data_ok[%0d]", i), 32'(dok[i]), 32'd0);
                end else begin
                    e = q[i].pop_front();
                    chk($sformatf("rdata[%0d]", i), rdo[i], e.rd);
                    chk($sformatf("data_ok_cycle[%0d]", i), 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    task automatic issue(input int i, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d,
                         input logic [31:0] e, output int acc);
        bit got = 1'b0;
        acc       = -1;
        req_d[i]  = 1'b1;
        wr_d[i]   = w;
        addr_d[i] = a;
        ws_d[i]   = s;
        wd_d[i]   = d;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (aok[i]) begin
                got = 1'b1;
                acc = cyc;
                q[i].push_back('{rd: e, due: cyc + lat_of(i)});
            end
        end
        if (!got) chk($sformatf("accept_timeout[%0d]", i), 32'(aok[i]), 32'd1);
        @(posedge clk);
        #1;
        req_d[i] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (q[0].size() + q[1].size() + q[2].size() == 0) break;
            @(negedge clk);
        end
        for (int i = 0; i < NI; i++) begin
            if (q[i].size() != 0) begin
                chk($sformatf("drain_timeout[%0d]", i), 32'(q[i].size()), 32'd0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc [6];
        int a;
        int prev;
        for (int i = 0; i < NI; i++) begin
            req_d[i]  = 1'b0;
            wr_d[i]   = 1'b0;
            addr_d[i] = '0;
            ws_d[i]   = '0;
            wd_d[i]   = '0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset_addr_ok", 32'(aok[i]), 32'd0);
            chk("reset_data_ok", 32'(dok[i]), 32'd0);
            chk("reset_rdata", rdo[i], 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk("post_reset_addr_ok", 32'(aok[i]), 32'd1);
        @(posedge clk);
        #1;

        // latency 2: full write, merges, no-op strobe, wrap
        issue(0, 1'b1, 32'h100, 4'hF, 32'h11223344, 32'h0, a);
        issue(0, 1'b0, 32'h100, 4'h0, 32'h0, 32'h11223344, a);
        issue(0, 1'b1, 32'h100, 4'b0011, 32'hAABBCCDD, 32'h0, a);
        issue(0, 1'b0, 32'h100, 4'h0, 32'h0, 32'h1122CCDD, a);
        issue(0, 1'b1, 32'h100, 4'h0, 32'hFFFFFFFF, 32'h0, a);
        issue(0, 1'b0, 32'h100, 4'h0, 32'h0, 32'h1122CCDD, a);
        issue(0, 1'b1, 32'h100, 4'b1000, 32'h99000000, 32'h0, a);
        issue(0, 1'b0, 32'h100, 4'h0, 32'h0, 32'h9922CCDD, a);
        issue(0, 1'b1, 32'h0, 4'hF, 32'hDEADBEEF, 32'h0, a);
        issue(0, 1'b0, MW * 4, 4'h0, 32'h0, 32'hDEADBEEF, a);
        issue(0, 1'b0, MW * 4 + 32'h100, 4'h0, 32'h0, 32'h9922CCDD, a);
        drain();

        // latency 8: fill to MAX_OUT and observe back-pressure
        for (int k = 0; k < 5; k++) begin
            issue(1, 1'b1, 32'h200 + 32'(4 * k), 4'hF, 32'hC0DE0000 + 32'(k), 32'h0, a);
        end
        drain();
        for (int k = 0; k < 5; k++) begin
            issue(1, 1'b0, 32'h200 + 32'(4 * k), 4'h0, 32'h0, 32'hC0DE0000 + 32'(k), acc[k]);
        end
        chk("b2b_4th_accept", 32'(acc[3] - acc[0]), 32'd3);
        chk("full_stall_gap", 32'(acc[4] - acc[3]), 32'd6);
        chk("5th_after_1st_dok", 32'(acc[4] - acc[0]), 32'd9);
        drain();

        // latency 1: req held high, write/read pairs, one accept per cycle
        prev = -1;
        for (int j = 0; j < 12; j++) begin
            if (j % 2 == 0) begin
                issue(2, 1'b1, 32'h300 + 32'(4 * (j / 2)), 4'hF,
                      32'h5A000000 + 32'(j), 32'h0, a);
            end else begin
                issue(2, 1'b0, 32'h300 + 32'(4 * (j / 2)), 4'h0, 32'h0,
                      32'h5A000000 + 32'(j - 1), a);
            end
            if (j > 0) chk("lat1_accept_gap", 32'(a - prev), 32'd1);
            prev = a;
        end
        drain();

        // reset with three requests outstanding at latency 8
        issue(1, 1'b0, 32'h200, 4'h0, 32'h0, 32'hC0DE0000, a);
        issue(1, 1'b0, 32'h204, 4'h0, 32'h0, 32'hC0DE0001, a);
        issue(1, 1'b0, 32'h208, 4'h0, 32'h0, 32'hC0DE0002, a);
        reset = 1'b1;
        q[1].delete();
        @(negedge clk);
        chk("midreset_addr_ok", 32'(aok[1]), 32'd0);
        chk("midreset_data_ok", 32'(dok[1]), 32'd0);
        chk("midreset_rdata", rdo[1], 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("after_reset_addr_ok", 32'(aok[1]), 32'd1);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;
        issue(1, 1'b0, 32'h20C, 4'h0, 32'h0, 32'hC0DE0003, a);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
